// File: rtl/jedro_1_test_pkg.sv
// jedro_1_test_pkg
// Shared types and defaults for the jedro_1 end-of-test checker.
//   state_e  : checker FSM states
//   result_t : latched test outcome (pass, timeout, first failing index, its value)
//   DEFAULT_MAX_CYCLES / DEFAULT_DRAIN_CYCLES : default parameter values
package jedro_1_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEFAULT_MAX_CYCLES   = 32;
  localparam int DEFAULT_DRAIN_CYCLES = 3;

  // The result fields are sized for the widest supported configuration
  // (up to 16 index bits and 64 data bits); the checker uses the low bits.
  localparam int RES_IDX_W = 16;
  localparam int RES_GOT_W = 64;

  typedef struct packed {
    logic                 pass;
    logic                 timeout;
    logic [RES_IDX_W-1:0] idx;
    logic [RES_GOT_W-1:0] got;
  } result_t;

endpackage

// File: rtl/jedro_1_shadow_regfile.sv
// jedro_1_shadow_regfile
// Shadow copy of the core's register file, fed from the regfile write port.
//   clk_i, rstn_i : clock and synchronous active-low reset (clears all entries)
//   we_i, waddr_i, wdata_i : snooped write port; writes to x0 are dropped
//   raddr_i, rdata_o : combinational read of the registered contents
module jedro_1_shadow_regfile
  import jedro_1_test_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      we_i,
  input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Capture every architectural write except to x0, which stays hard-wired
  // to zero. Addresses beyond NUM_REGS are ignored.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0) && (32'(waddr_i) < NUM_REGS)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see only the registered contents, so a write in the same cycle
  // becomes visible on the following cycle.
  always_comb begin
    rdata_o = '0;
    if ((raddr_i != '0) && (32'(raddr_i) < NUM_REGS)) begin
      rdata_o = regs_q[raddr_i];
    end
  end

endmodule

// File: rtl/jedro_1_test_checker.sv
// jedro_1_test_checker
// End-of-test checker for jedro_1 directed instruction tests. Shadows the
// register file, runs a test window ended by an illegal instruction or a
// cycle budget, drains the pipeline, then compares masked registers.
//   clk_i, rstn_i      : clock, synchronous active-low reset
//   start_i            : begin a test window (accepted in IDLE or DONE)
//   illegal_instr_i    : end-of-test marker from the decoder
//   rd_we_i/addr/data  : snooped regfile write port
//   expected_i         : expected values, reg n at [n*DATA_WIDTH +: DATA_WIDTH]
//   check_mask_i       : bit n set = compare reg n
//   busy_o, done_o     : in RUN/DRAIN/CHECK, in DONE
//   pass_o, timeout_o  : outcome flags
//   mismatch_idx_o/got : first failing register and its shadow value
//   cycle_count_o      : cycles spent in RUN
module jedro_1_test_checker
  import jedro_1_test_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_CYCLES     = DEFAULT_MAX_CYCLES,
  parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic                           illegal_instr_i,
  input  logic                           rd_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]      rd_addr_i,
  input  logic [DATA_WIDTH-1:0]          rd_data_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] expected_i,
  input  logic [NUM_REGS-1:0]            check_mask_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           timeout_o,
  output logic [REG_ADDR_WIDTH-1:0]      mismatch_idx_o,
  output logic [DATA_WIDTH-1:0]          mismatch_got_o,
  output logic [CNT_WIDTH-1:0]           cycle_count_o
);

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cycle_cnt_q;
  logic [CNT_WIDTH-1:0]      drain_cnt_q;
  logic [REG_ADDR_WIDTH-1:0] check_idx_q;
  logic                      check_end_q;
  logic                      found_q;
  result_t                   res_q;

  logic [DATA_WIDTH-1:0]     shadow_rdata;
  logic [DATA_WIDTH-1:0]     exp_word;
  logic                      run_illegal;
  logic                      run_budget;
  logic                      drain_last;
  logic                      check_hit;
  logic                      check_at_last;
  logic                      res_unused;

  jedro_1_shadow_regfile #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_REGS       (NUM_REGS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_shadow (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .we_i    (rd_we_i),
    .waddr_i (rd_addr_i),
    .wdata_i (rd_data_i),
    .raddr_i (check_idx_q),
    .rdata_o (shadow_rdata)
  );

  // The illegal-instruction marker takes priority over the budget, so a
  // test that ends exactly on its last budgeted cycle is not a timeout.
  assign run_illegal   = (state_q == ST_RUN) && illegal_instr_i;
  assign run_budget    = (state_q == ST_RUN) && !illegal_instr_i &&
                         (32'(cycle_cnt_q) == MAX_CYCLES - 1);
  assign drain_last    = (state_q == ST_DRAIN) &&
                         (32'(drain_cnt_q) == DRAIN_CYCLES - 1);
  assign exp_word      = expected_i[32'(check_idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign check_hit     = check_mask_i[check_idx_q] && (shadow_rdata != exp_word);
  assign check_at_last = (32'(check_idx_q) == NUM_REGS - 1);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. CHECK leaves one cycle after the comparison that ends
  // it, so the latched result is stable on the cycle done_o rises.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (run_illegal || run_budget) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_CHECK;
      ST_CHECK: if (check_end_q) state_d = ST_DONE;
      ST_DONE:  if (start_i) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, check sequencing and the result latch. The cycle counter
  // saturates rather than wrapping; found_q remembers a mismatch so that
  // pass can be decided on the transition into DONE.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
      check_idx_q <= '0;
      check_end_q <= 1'b0;
      found_q     <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cycle_cnt_q <= '0;
            found_q     <= 1'b0;
            res_q       <= '0;
          end
        end
        ST_RUN: begin
          if (cycle_cnt_q != '1) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
          end
          if (run_illegal) begin
            drain_cnt_q <= '0;
          end else if (run_budget) begin
            drain_cnt_q   <= '0;
            res_q.timeout <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_last) begin
            check_idx_q <= '0;
            check_end_q <= 1'b0;
            found_q     <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_CHECK: begin
          if (check_end_q) begin
            res_q.pass <= !found_q;
          end else if (check_hit) begin
            res_q.idx   <= RES_IDX_W'(check_idx_q);
            res_q.got   <= RES_GOT_W'(shadow_rdata);
            found_q     <= 1'b1;
            check_end_q <= 1'b1;
          end else if (check_at_last) begin
            check_end_q <= 1'b1;
          end else begin
            check_idx_q <= check_idx_q + REG_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs follow the state; results come from the latch. The
  // result fields are wider than this configuration needs, so the spare
  // high bits are folded into a deliberately unused signal.
  assign busy_o         = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                          (state_q == ST_CHECK);
  assign done_o         = (state_q == ST_DONE);
  assign pass_o         = res_q.pass;
  assign timeout_o      = res_q.timeout;
  assign mismatch_idx_o = res_q.idx[REG_ADDR_WIDTH-1:0];
  assign mismatch_got_o = res_q.got[DATA_WIDTH-1:0];
  assign cycle_count_o  = cycle_cnt_q;
  assign res_unused     = ^{res_q.idx, res_q.got};

endmodule

// File: tb/tb_jedro_1_test_checker.sv
// tb_jedro_1_test_checker
// Self-checking bench for jedro_1_test_checker: directed scenarios plus
// randomized test windows checked against a behavioural model of the
// register state and the checker's pass/fail/latency rules.
module tb_jedro_1_test_checker;

  localparam int DW       = 32;
  localparam int NR       = 32;
  localparam int AW       = 5;
  localparam int MAXC     = 32;
  localparam int DRN      = 3;
  localparam int CW       = 16;
  localparam int POST_MAX = 1 + DRN + NR + 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic           illegal;
  logic           we;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data;
  logic [NR*DW-1:0] expected_v;
  logic [NR-1:0]  mask;
  logic           busy, done, pass, timeout;
  logic [AW-1:0]  mm_idx;
  logic [DW-1:0]  mm_got;
  logic [CW-1:0]  cyc;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural register state as the core would have written it.
  logic [DW-1:0] model_regs [NR];

  // Per-cycle write schedules for the RUN phase and the post-trigger phase.
  logic          run_we    [MAXC+1];
  logic [AW-1:0] run_addr  [MAXC+1];
  logic [DW-1:0] run_data  [MAXC+1];
  logic          run_start [MAXC+1];
  logic          post_we   [POST_MAX+1];
  logic [AW-1:0] post_addr [POST_MAX+1];
  logic [DW-1:0] post_data [POST_MAX+1];

  always #5 clk = ~clk;

  jedro_1_test_checker #(
    .DATA_WIDTH     (DW),
    .NUM_REGS       (NR),
    .REG_ADDR_WIDTH (AW),
    .MAX_CYCLES     (MAXC),
    .DRAIN_CYCLES   (DRN),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .start_i         (start),
    .illegal_instr_i (illegal),
    .rd_we_i         (we),
    .rd_addr_i       (addr),
    .rd_data_i       (data),
    .expected_i      (expected_v),
    .check_mask_i    (mask),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .timeout_o       (timeout),
    .mismatch_idx_o  (mm_idx),
    .mismatch_got_o  (mm_got),
    .cycle_count_o   (cyc)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, and update the model.
  task automatic applyStimulus(input logic s, input logic il, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    start   = s;
    illegal = il;
    we      = w;
    addr    = a;
    data    = d;
    @(posedge clk);
    #1;
    if (!rstn) begin
      for (int i = 0; i < NR; i++) model_regs[i] = '0;
    end else if (w && a != '0) begin
      model_regs[a] = d;
    end
  endtask

  task automatic clearSchedule();
    for (int i = 0; i <= MAXC; i++) begin
      run_we[i] = 1'b0; run_addr[i] = '0; run_data[i] = '0; run_start[i] = 1'b0;
    end
    for (int i = 0; i <= POST_MAX; i++) begin
      post_we[i] = 1'b0; post_addr[i] = '0; post_data[i] = '0;
    end
  endtask

  task automatic setExpected(input int idx, input logic [DW-1:0] v);
    expected_v[idx*DW +: DW] = v;
  endtask

  // One full test window: start pulse, RUN until the trigger, then drain and
  // check. The model decides pass/fail and when done must rise: index i is
  // judged against the register state just before post-trigger edge DRN+1+i,
  // and done follows one edge after the deciding comparison.
  task automatic runTest(input int illegal_at, input string name);
    int            c;
    int            done_at;
    int            done_j;
    int            exp_idx;
    int            i;
    logic          il;
    logic          exp_to;
    logic          exp_pass;
    logic [DW-1:0] exp_got;
    bit            decided;

    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput({name, "/start_busy"},  64'(busy), 64'd1);
    checkOutput({name, "/start_done"},  64'(done), 64'd0);
    checkOutput({name, "/start_pass"},  64'(pass), 64'd0);
    checkOutput({name, "/start_tmo"},   64'(timeout), 64'd0);
    checkOutput({name, "/start_idx"},   64'(mm_idx), 64'd0);
    checkOutput({name, "/start_got"},   64'(mm_got), 64'd0);
    checkOutput({name, "/start_count"}, 64'(cyc), 64'd0);

    c  = 0;
    il = 1'b0;
    for (int k = 1; k <= MAXC; k++) begin
      c  = k;
      il = (k == illegal_at);
      applyStimulus(run_start[k], il, run_we[k], run_addr[k], run_data[k]);
      if (il) break;
    end
    exp_to = !il;

    decided  = 0;
    exp_pass = 1'b0;
    exp_idx  = 0;
    exp_got  = '0;
    done_j   = -1;
    done_at  = -1;
    for (int j = 1; j <= POST_MAX; j++) begin
      if (!decided && j >= DRN + 1) begin
        i = j - DRN - 1;
        if (mask[i] && model_regs[i] !== expected_v[i*DW +: DW]) begin
          decided  = 1;
          exp_pass = 1'b0;
          exp_idx  = i;
          exp_got  = model_regs[i];
          done_j   = j + 1;
        end else if (i == NR - 1) begin
          decided  = 1;
          exp_pass = 1'b1;
          done_j   = j + 1;
        end
      end
      applyStimulus(1'b0, 1'b0, post_we[j], post_addr[j], post_data[j]);
      if (done) begin
        done_at = j;
        break;
      end
    end

    checkOutput({name, "/latency"}, 64'(done_at), 64'(done_j));
    checkOutput({name, "/done"},    64'(done), 64'd1);
    checkOutput({name, "/busy"},    64'(busy), 64'd0);
    checkOutput({name, "/pass"},    64'(pass), 64'(exp_pass));
    checkOutput({name, "/timeout"}, 64'(timeout), 64'(exp_to));
    checkOutput({name, "/count"},   64'(cyc), 64'(c));
    checkOutput({name, "/mm_idx"},  64'(mm_idx), 64'(exp_idx));
    checkOutput({name, "/mm_got"},  64'(mm_got), 64'(exp_got));
  endtask

  task automatic addiSchedule();
    clearSchedule();
    run_we[1] = 1'b1; run_addr[1] = 5'd1; run_data[1] = 32'd1;
    run_we[2] = 1'b1; run_addr[2] = 5'd1; run_data[2] = 32'd3;
    run_we[3] = 1'b1; run_addr[3] = 5'd1; run_data[3] = 32'd6;
    run_we[4] = 1'b1; run_addr[4] = 5'd1; run_data[4] = 32'd10;
    run_we[5] = 1'b1; run_addr[5] = 5'd1; run_data[5] = 32'd15;
  endtask

  task automatic randomSchedule();
    clearSchedule();
    for (int k = 1; k <= MAXC; k++) begin
      run_we[k]    = ($urandom_range(0, 1) == 1);
      run_addr[k]  = AW'($urandom_range(0, NR - 1));
      run_data[k]  = $urandom;
      run_start[k] = ($urandom_range(0, 3) == 0);
    end
    for (int k = 1; k <= POST_MAX; k++) begin
      post_we[k]   = ($urandom_range(0, 4) == 0);
      post_addr[k] = AW'($urandom_range(0, NR - 1));
      post_data[k] = $urandom;
    end
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    illegal    = 1'b0;
    we         = 1'b0;
    addr       = '0;
    data       = '0;
    expected_v = '0;
    mask       = '0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("rst/busy",    64'(busy), 64'd0);
    checkOutput("rst/done",    64'(done), 64'd0);
    checkOutput("rst/pass",    64'(pass), 64'd0);
    checkOutput("rst/timeout", 64'(timeout), 64'd0);
    checkOutput("rst/idx",     64'(mm_idx), 64'd0);
    checkOutput("rst/got",     64'(mm_got), 64'd0);
    checkOutput("rst/count",   64'(cyc), 64'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    $display("[TB] addi chain, matching x1");
    addiSchedule();
    for (int i = 0; i < NR; i++) setExpected(i, $urandom);
    setExpected(1, 32'd15);
    mask = 32'h0000_0002;
    runTest(7, "addi");

    $display("[TB] addi chain, wrong x1");
    addiSchedule();
    setExpected(1, 32'd14);
    runTest(7, "addi_bad");

    $display("[TB] restart from DONE, shadow retained");
    clearSchedule();
    setExpected(1, 32'd15);
    runTest(5, "restart");

    $display("[TB] budget timeout");
    clearSchedule();
    runTest(0, "budget");

    $display("[TB] x0 write and late drain write");
    clearSchedule();
    run_we[1]    = 1'b1; run_addr[1]  = 5'd0; run_data[1]  = 32'd5;
    post_we[2]   = 1'b1; post_addr[2] = 5'd2; post_data[2] = 32'd7;
    setExpected(0, 32'd0);
    setExpected(2, 32'd7);
    mask = 32'h0000_0005;
    runTest(4, "x0_drain");

    $display("[TB] illegal on last budget cycle");
    clearSchedule();
    runTest(MAXC, "illegal_last");

    $display("[TB] randomized windows");
    for (int t = 0; t < 8; t++) begin
      randomSchedule();
      mask = $urandom;
      if (t % 2 == 0) begin
        mask = mask & 32'h0000_FFFF;
        for (int k = 1; k <= MAXC; k++) run_addr[k] = run_addr[k] | 5'h10;
      end
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) != 0) setExpected(i, model_regs[i]);
        else                           setExpected(i, $urandom);
      end
      runTest($urandom_range(0, MAXC), $sformatf("rand%0d", t));
    end

    $display("[TB] reset during CHECK");
    clearSchedule();
    mask = '1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    for (int j = 1; j <= DRN + 2; j++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("midchk/busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("midrst/busy",    64'(busy), 64'd0);
    checkOutput("midrst/done",    64'(done), 64'd0);
    checkOutput("midrst/pass",    64'(pass), 64'd0);
    checkOutput("midrst/timeout", 64'(timeout), 64'd0);
    checkOutput("midrst/idx",     64'(mm_idx), 64'd0);
    checkOutput("midrst/got",     64'(mm_got), 64'd0);
    checkOutput("midrst/count",   64'(cyc), 64'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    expected_v = '0;
    mask       = '1;
    runTest(3, "after_reset");

    $display("[TB] empty mask");
    clearSchedule();
    for (int i = 0; i < NR; i++) setExpected(i, $urandom | 32'h1);
    mask = '0;
    runTest(2, "empty_mask");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
